pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencing for the 16-bit pipeline: boot, run,
// drain-on-HLT and terminal halt, with branch redirect and hazard stall.
module pc_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        hlt_fetch,
  input  logic        hlt_commit,
  output logic [15:0] pc_curr,
  output logic [15:0] pc_next,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [15:0] pc_r;
  logic [15:0] pc_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [15:0] br_dest_s;
  logic        fetch_valid_r;
  logic        halted_r;

  // Branch destinations are forced to halfword alignment.
  assign br_dest_s = br_target & 16'hFFFE;

  // Next-state, next-PC and fetch-count selection.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (br_taken) begin
          pc_nxt_s = br_dest_s;
        end else if (stall) begin
          pc_nxt_s = pc_r;
        end else if (hlt_fetch) begin
          // The HLT fetch itself is an accepted fetch; the PC parks on it.
          cnt_nxt_s   = cnt_r + 16'd1;
          state_nxt_s = ST_DRAIN;
        end else begin
          pc_nxt_s  = pc_r + 16'd2;
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (br_taken) begin
          pc_nxt_s    = br_dest_s;
          state_nxt_s = ST_RUN;
        end else if (hlt_commit) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_BOOT;
        pc_nxt_s    = 16'h0000;
        cnt_nxt_s   = 16'h0000;
      end
    endcase
  end

  // State, PC, counter and decoded status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= 16'h0000;
      cnt_r         <= 16'h0000;
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      cnt_r         <= cnt_nxt_s;
      fetch_valid_r <= (state_nxt_s == ST_RUN);
      halted_r      <= (state_nxt_s == ST_HALT);
    end
  end

  // flush_ifid is the only output with a combinational path from an input.
  assign flush_ifid  = br_taken & ((state_r == ST_RUN) | (state_r == ST_DRAIN));
  assign pc_curr     = pc_r;
  assign pc_next     = pc_r + 16'd2;
  assign fetch_cnt   = cnt_r;
  assign fetch_valid = fetch_valid_r;
  assign halted      = halted_r;

endmodule
